// File: rtl/fmdll_freq_det_if.sv
// rtl/fmdll_freq_det_if.sv - interface bundle for the FMDLL frequency detector
//
// Purpose: groups the reference clock input, control inputs and measurement
// outputs of fmdll_freq_det so the detector and its driver share one port.
// Signals:
//   clk_ext    reference clock, treated as asynchronous data by the detector
//   en         measurement enable
//   N, M       multiplication / division factors (latched when leaving IDLE)
//   up, dn     correction flags (clk_out too slow / too fast)
//   lock       hysteretic frequency lock
//   meas_valid one-cycle pulse when a window closes
//   meas_cnt   clk_out cycle count of the last window
// Modports: master drives clk_ext/en/N/M, slave (the detector) drives results.
interface fmdll_freq_det_if #(
  parameter int N_W   = 4,
  parameter int M_W   = 2,
  parameter int CNT_W = 8
);
  logic             clk_ext;
  logic             en;
  logic [N_W-1:0]   N;
  logic [M_W-1:0]   M;
  logic             up;
  logic             dn;
  logic             lock;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_cnt;

  modport master (
    output clk_ext, en, N, M,
    input  up, dn, lock, meas_valid, meas_cnt
  );

  modport slave (
    input  clk_ext, en, N, M,
    output up, dn, lock, meas_valid, meas_cnt
  );
endinterface

// File: rtl/fmdll_freq_det.sv
// rtl/fmdll_freq_det.sv - closed-window frequency detector for the FMDLL loop
//
// Purpose: counts clk_out cycles over WIN_MULT*M reference periods and
// compares the count with WIN_MULT*N, producing up/dn correction flags and a
// hysteretic lock indicator. Everything runs in the clk_out domain; clk_ext is
// synchronised as data.
// Ports:
//   clk_out  sole clock
//   rst      synchronous active-high reset
//   bus      fmdll_freq_det_if.slave (clk_ext, en, N, M in; up, dn, lock,
//            meas_valid, meas_cnt out)
module fmdll_freq_det #(
  parameter int N_W      = 4,
  parameter int M_W      = 2,
  parameter int WIN_MULT = 4,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 3,
  parameter int CNT_W    = N_W + $clog2(WIN_MULT) + 2
) (
  input  logic             clk_out,
  input  logic             rst,
  fmdll_freq_det_if.slave  bus
);

  localparam int E_W  = M_W + $clog2(WIN_MULT) + 1;
  localparam int LC_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             ref_rise;
  logic [N_W-1:0]   n_q, n_d;
  logic [M_W-1:0]   m_q, m_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [E_W-1:0]   edge_q, edge_d;
  logic [LC_W-1:0]  in_q, in_d;
  logic [1:0]       out_q, out_d;
  logic             up_q, up_d, dn_q, dn_d, lock_q, lock_d, mv_q, mv_d;
  logic [CNT_W-1:0] mc_q, mc_d;

  logic             params_bad, win_close, timeout;
  logic [E_W-1:0]   win_target, edge_inc;
  logic [CNT_W-1:0] cnt_now, exp_cnt;
  logic [CNT_W:0]   cnt_hi, exp_hi;
  logic             too_slow, too_fast, in_band;

  // Two-flop synchroniser plus edge flop: fixed 3-cycle latency on every
  // reference edge, so it cancels out over a window.
  always_ff @(posedge clk_out) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.clk_ext;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign ref_rise   = s2_q & ~s3_q;
  assign params_bad = (n_q == '0) || (m_q == '0);
  assign win_target = E_W'(m_q) * E_W'(WIN_MULT);
  assign edge_inc   = edge_q + E_W'(1);
  assign win_close  = (state_q == S_MEAS) && ref_rise && (edge_inc == win_target);
  // Reference stopped: the count would saturate this cycle without a close.
  assign timeout    = (state_q == S_MEAS) && !win_close && (cyc_q == CNT_MAX - CNT_W'(1));

  // Count including the current cycle; compared without subtraction so that
  // small expected values cannot underflow.
  assign cnt_now  = timeout ? CNT_MAX : cyc_q + CNT_W'(1);
  assign exp_cnt  = CNT_W'(n_q) * CNT_W'(WIN_MULT);
  assign cnt_hi   = {1'b0, cnt_now} + (CNT_W+1)'(TOL);
  assign exp_hi   = {1'b0, exp_cnt} + (CNT_W+1)'(TOL);
  assign too_slow = cnt_hi < {1'b0, exp_cnt};
  assign too_fast = {1'b0, cnt_now} > exp_hi;
  assign in_band  = !too_slow && !too_fast && !timeout;

  // FSM state register
  always_ff @(posedge clk_out) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (!bus.en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARM;
        S_ARM: begin
          if (params_bad)    state_d = S_IDLE;
          else if (ref_rise) state_d = S_MEAS;
        end
        S_MEAS: if (timeout) state_d = S_ARM;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    n_d    = n_q;
    m_d    = m_q;
    cyc_d  = cyc_q;
    edge_d = edge_q;
    in_d   = in_q;
    out_d  = out_q;
    up_d   = up_q;
    dn_d   = dn_q;
    lock_d = lock_q;
    mv_d   = 1'b0;
    mc_d   = mc_q;
    if (!bus.en || state_q == S_IDLE) begin
      cyc_d  = '0;
      edge_d = '0;
      in_d   = '0;
      out_d  = '0;
      up_d   = 1'b0;
      dn_d   = 1'b0;
      lock_d = 1'b0;
      if (!bus.en) begin
        mc_d = '0;
      end else begin
        n_d = bus.N;
        m_d = bus.M;
      end
    end else if (state_q == S_ARM) begin
      if (ref_rise) begin
        cyc_d  = '0;
        edge_d = '0;
      end
    end else if (state_q == S_MEAS) begin
      cyc_d = cyc_q + CNT_W'(1);
      if (ref_rise) edge_d = edge_inc;
      if (win_close || timeout) begin
        // The closing edge also arms the next window, hence the clear.
        mv_d   = 1'b1;
        mc_d   = cnt_now;
        cyc_d  = '0;
        edge_d = '0;
        up_d   = timeout ? 1'b0 : too_slow;
        dn_d   = timeout ? 1'b1 : too_fast;
        if (in_band) begin
          in_d  = (in_q == LC_W'(LOCK_CNT)) ? in_q : in_q + LC_W'(1);
          out_d = '0;
          if (in_d == LC_W'(LOCK_CNT)) lock_d = 1'b1;
        end else begin
          in_d  = '0;
          out_d = (out_q == 2'd2) ? out_q : out_q + 2'd1;
          if (out_d == 2'd2) lock_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_out) begin
    if (rst) begin
      n_q    <= '0;
      m_q    <= '0;
      cyc_q  <= '0;
      edge_q <= '0;
      in_q   <= '0;
      out_q  <= '0;
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
      lock_q <= 1'b0;
      mv_q   <= 1'b0;
      mc_q   <= '0;
    end else begin
      n_q    <= n_d;
      m_q    <= m_d;
      cyc_q  <= cyc_d;
      edge_q <= edge_d;
      in_q   <= in_d;
      out_q  <= out_d;
      up_q   <= up_d;
      dn_q   <= dn_d;
      lock_q <= lock_d;
      mv_q   <= mv_d;
      mc_q   <= mc_d;
    end
  end

  assign bus.up         = up_q;
  assign bus.dn         = dn_q;
  assign bus.lock       = lock_q;
  assign bus.meas_valid = mv_q;
  assign bus.meas_cnt   = mc_q;

endmodule
